// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, fflags layout, format geometry,
// canonical NaNs and operand classification.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam int SP_BIAS  = 127;
  localparam int DP_EXP_W = 11;
  localparam int DP_MAN_W = 52;
  localparam int DP_BIAS  = 1023;
  localparam int SD_REBIAS = DP_BIAS - SP_BIAS;

  localparam logic [63:0] DP_QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] SP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] NANBOX     = 32'hFFFF_FFFF;
  localparam logic [30:0] SP_MAX_MAG = 31'h7F7F_FFFF;
  localparam logic [30:0] SP_INF_MAG = 31'h7F80_0000;

  typedef enum logic [2:0] {
    CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN
  } fp_class_e;

  function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic man_zero, input logic man_msb);
    if (exp_zero)      return man_zero ? CLS_ZERO : CLS_SUB;
    else if (!exp_ones) return CLS_NORM;
    else if (man_zero)  return CLS_INF;
    else                return man_msb ? CLS_QNAN : CLS_SNAN;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Generic significand rounder driven by guard/round/sticky; shared by the
// converter and the arithmetic units.
module fp_round
  import fpu_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             sign,
  input  logic [2:0]       rm,
  input  logic [WIDTH-1:0] sig,
  input  logic             guard,
  input  logic             round,
  input  logic             sticky,
  output logic [WIDTH-1:0] sig_out,
  output logic             carry,
  output logic             inexact
);

  logic round_up;

  always_comb begin
    inexact = guard | round | sticky;
    case (rm)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sign & inexact;
      RM_RUP:  round_up = ~sign & inexact;
      RM_RMM:  round_up = guard;
      // Reserved encodings fall back to round-to-nearest-even.
      default: round_up = guard & (round | sticky | sig[0]);
    endcase
    {carry, sig_out} = {1'b0, sig} + {{WIDTH{1'b0}}, round_up};
  end

endmodule

// File: rtl/fcvt_sd_pipe.sv
// Three-stage single<->double converter (unpack / convert / round-pack) with
// valid/ready on both sides; the whole pipe freezes while the output is stalled.
module fcvt_sd_pipe
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_WIDTH = 5,
  parameter int STAGES    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op,
  input  logic [2:0]           in_rm,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [4:0]           out_flags,
  output logic [TAG_WIDTH-1:0] out_tag
);

  if (BUS_WIDTH != 64 || STAGES != 3) begin : g_bad_cfg
    $error("fcvt_sd_pipe supports only BUS_WIDTH=64 and STAGES=3");
  end

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage 1: unpack and classify.
  logic                 s1_valid, s1_op, s1_sign;
  logic [2:0]           s1_rm;
  logic [TAG_WIDTH-1:0] s1_tag;
  fp_class_e            s1_cls;
  logic [10:0]          s1_exp;
  logic [51:0]          s1_man;
  logic                 u_sign;
  fp_class_e            u_cls;
  logic [10:0]          u_exp;
  logic [51:0]          u_man;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    u_sign = 1'b0;
    u_exp  = '0;
    u_man  = '0;
    u_cls  = CLS_QNAN;
    if (in_op) begin
      u_sign = in_data[63];
      u_exp  = in_data[62:52];
      u_man  = in_data[51:0];
      u_cls  = classify(~|in_data[62:52], &in_data[62:52], ~|in_data[51:0], in_data[51]);
    end else if (&in_data[63:32]) begin
      u_sign = in_data[31];
      u_exp  = {3'b000, in_data[30:23]};
      u_man  = {in_data[22:0], 29'b0};
      u_cls  = classify(~|in_data[30:23], &in_data[30:23], ~|in_data[22:0], in_data[22]);
    end
  end

  // Stage 2: convert. S->D is exact and fully packed here; D->S leaves a
  // 24-bit significand plus guard/round/sticky for the rounder.
  logic                 s2_valid, s2_sign, s2_special, s2_sub, s2_g, s2_r, s2_s;
  logic [2:0]           s2_rm;
  logic [TAG_WIDTH-1:0] s2_tag;
  logic [63:0]          s2_spec_data;
  logic [4:0]           s2_spec_flags;
  logic [23:0]          s2_sig;
  logic [11:0]          s2_exp;
  logic                 c_special, c_sub, c_st;
  logic [63:0]          c_spec_data;
  logic [4:0]           c_spec_flags;
  logic [11:0]          c_exp;
  logic signed [11:0]   e_pre;
  logic [4:0]           lzc, sh;
  logic [51:0]          sub_man;
  logic [25:0]          v, lost_mask;

  always_comb begin
    c_special    = 1'b1;
    c_sub        = 1'b0;
    c_spec_data  = '0;
    c_spec_flags = '0;
    c_exp        = '0;
    c_st         = 1'b0;
    e_pre        = '0;
    sh           = '0;
    v            = '0;
    lost_mask    = '0;
    lzc          = '0;
    for (int i = 29; i <= 51; i++) if (s1_man[i]) lzc = 5'(51 - i);
    sub_man = s1_man << (lzc + 5'd1);
    if (!s1_op) begin
      case (s1_cls)
        CLS_ZERO: c_spec_data = {s1_sign, 63'b0};
        CLS_SUB:  c_spec_data = {s1_sign, 11'(SD_REBIAS) - {6'b0, lzc}, sub_man};
        CLS_NORM: c_spec_data = {s1_sign, s1_exp + 11'(SD_REBIAS), s1_man};
        CLS_INF:  c_spec_data = {s1_sign, 11'h7FF, 52'b0};
        CLS_SNAN: begin
          c_spec_data           = DP_QNAN;
          c_spec_flags[FLAG_NV] = 1'b1;
        end
        default:  c_spec_data = DP_QNAN;
      endcase
    end else begin
      case (s1_cls)
        CLS_ZERO: c_spec_data = {NANBOX, s1_sign, 31'b0};
        CLS_INF:  c_spec_data = {NANBOX, s1_sign, SP_INF_MAG};
        CLS_QNAN: c_spec_data = {NANBOX, SP_QNAN};
        CLS_SNAN: begin
          c_spec_data           = {NANBOX, SP_QNAN};
          c_spec_flags[FLAG_NV] = 1'b1;
        end
        default: begin
          c_special = 1'b0;
          e_pre = ((s1_cls == CLS_NORM) ? $signed({1'b0, s1_exp}) : 12'sd1) - 12'sd896;
          v     = {s1_cls == CLS_NORM, s1_man[51:27]};
          c_st  = |s1_man[26:0];
          if (e_pre <= 12'sd0) begin
            // Denormalise: shift right by 1-e, capped at 26 so everything lands in sticky.
            sh        = (e_pre < -12'sd25) ? 5'd26 : 5'(12'sd1 - e_pre);
            lost_mask = ~(26'h3FF_FFFF << sh);
            c_st      = c_st | (|(v & lost_mask));
            v         = v >> sh;
            c_sub     = 1'b1;
          end else begin
            c_exp = e_pre;
          end
        end
      endcase
    end
  end

  // Stage 3: round and pack.
  logic [23:0] r_sig;
  logic        r_carry, r_nx, of_max;
  logic [11:0] r_exp;
  logic [63:0] res_data;
  logic [4:0]  res_flags;

  fp_round #(.WIDTH(24)) u_round (
    .sign    (s2_sign),
    .rm      (s2_rm),
    .sig     (s2_sig),
    .guard   (s2_g),
    .round   (s2_r),
    .sticky  (s2_s),
    .sig_out (r_sig),
    .carry   (r_carry),
    .inexact (r_nx)
  );

  always_comb begin
    r_exp     = s2_exp + {11'b0, r_carry};
    res_data  = s2_spec_data;
    res_flags = s2_spec_flags;
    of_max    = 1'b0;
    if (!s2_special) begin
      res_flags = '0;
      if (s2_sub) begin
        // A carry into bit 23 promotes the subnormal to the minimum normal.
        res_data           = {NANBOX, s2_sign, 7'b0, r_sig[23], r_sig[22:0]};
        res_flags[FLAG_UF] = r_nx & ~r_sig[23];
        res_flags[FLAG_NX] = r_nx;
      end else if (r_exp >= 12'd255) begin
        case (s2_rm)
          RM_RTZ:  of_max = 1'b1;
          RM_RDN:  of_max = ~s2_sign;
          RM_RUP:  of_max = s2_sign;
          default: of_max = 1'b0;
        endcase
        res_data           = {NANBOX, s2_sign, of_max ? SP_MAX_MAG : SP_INF_MAG};
        res_flags[FLAG_OF] = 1'b1;
        res_flags[FLAG_NX] = 1'b1;
      end else begin
        res_data           = {NANBOX, s2_sign, r_exp[7:0], r_sig[22:0]};
        res_flags[FLAG_NX] = r_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data  <= res_data;
        out_flags <= res_flags;
        out_tag   <= s2_tag;
      end
    end
  end

  // NOTE: the stage payload has no reset; it is only ever observed under its valid bit.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_op         <= in_op;
      s1_rm         <= in_rm;
      s1_tag        <= in_tag;
      s1_sign       <= u_sign;
      s1_cls        <= u_cls;
      s1_exp        <= u_exp;
      s1_man        <= u_man;
      s2_rm         <= s1_rm;
      s2_tag        <= s1_tag;
      s2_sign       <= s1_sign;
      s2_special    <= c_special;
      s2_spec_data  <= c_spec_data;
      s2_spec_flags <= c_spec_flags;
      s2_sub        <= c_sub;
      s2_exp        <= c_exp;
      s2_sig        <= v[25:2];
      s2_g          <= v[1];
      s2_r          <= v[0];
      s2_s          <= c_st;
    end
  end

endmodule

// File: tb/tb_fcvt_sd_pipe.sv
// Directed bench for fcvt_sd_pipe: vector table plus latency, stall/ordering
// and reset-flush sequences.
module tb_fcvt_sd_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [2:0]  in_rm = 3'd0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [4:0]  out_flags;
  logic [4:0]  out_tag;

  fcvt_sd_pipe #(.BUS_WIDTH(64), .TAG_WIDTH(5), .STAGES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rm     (in_rm),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [2:0]  rm;
    logic [63:0] data;
    logic [63:0] res;
    logic [4:0]  flags;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs[NVEC];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input int i, input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = vecs[i].op;
    in_rm    = vecs[i].rm;
    in_data  = vecs[i].data;
    in_tag   = tag;
  endtask

  // Entered and left just after a rising edge.
  task automatic apply_one(input int i);
    int n;
    drive(i, 5'(i));
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin n++; @(negedge clk); end
    check($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
    check($sformatf("vec%0d data", i), out_data, vecs[i].res);
    check($sformatf("vec%0d flags", i), 64'(out_flags), 64'(vecs[i].flags));
    check($sformatf("vec%0d tag", i), 64'(out_tag), 64'(i));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, sent, got, cyc, stall_left, stale;
    bit stall_started, holding, acc;
    logic [63:0] h_data;
    logic [4:0]  h_flags, h_tag;

    //           op    rm      operand                 result                  flags
    vecs[0]  = '{1'b0, 3'd0, 64'hFFFFFFFF3F800000, 64'h3FF0000000000000, 5'h00};
    vecs[1]  = '{1'b1, 3'd0, 64'h3FF0000000000001, 64'hFFFFFFFF3F800000, 5'h01};
    vecs[2]  = '{1'b1, 3'd3, 64'h3FF0000000000001, 64'hFFFFFFFF3F800001, 5'h01};
    vecs[3]  = '{1'b1, 3'd0, 64'h7E37E43C8800759C, 64'hFFFFFFFF7F800000, 5'h05};
    vecs[4]  = '{1'b1, 3'd1, 64'h7E37E43C8800759C, 64'hFFFFFFFF7F7FFFFF, 5'h05};
    vecs[5]  = '{1'b0, 3'd0, 64'hFFFFFFFF7F800001, 64'h7FF8000000000000, 5'h10};
    vecs[6]  = '{1'b0, 3'd0, 64'h000000003F800000, 64'h7FF8000000000000, 5'h00};
    vecs[7]  = '{1'b0, 3'd0, 64'hFFFFFFFF00000001, 64'h36A0000000000000, 5'h00};
    vecs[8]  = '{1'b1, 3'd0, 64'h3690000000000000, 64'hFFFFFFFF00000000, 5'h03};
    vecs[9]  = '{1'b1, 3'd2, 64'h7E37E43C8800759C, 64'hFFFFFFFF7F7FFFFF, 5'h05};
    vecs[10] = '{1'b1, 3'd3, 64'hFE37E43C8800759C, 64'hFFFFFFFFFF7FFFFF, 5'h05};
    vecs[11] = '{1'b1, 3'd2, 64'hFE37E43C8800759C, 64'hFFFFFFFFFF800000, 5'h05};
    vecs[12] = '{1'b0, 3'd1, 64'hFFFFFFFF80000000, 64'h8000000000000000, 5'h00};
    vecs[13] = '{1'b1, 3'd3, 64'h3690000000000000, 64'hFFFFFFFF00000001, 5'h03};
    vecs[14] = '{1'b1, 3'd0, 64'hFFF0000000000000, 64'hFFFFFFFFFF800000, 5'h00};
    vecs[15] = '{1'b1, 3'd0, 64'h7FF8000000000000, 64'hFFFFFFFF7FC00000, 5'h00};
    vecs[16] = '{1'b1, 3'd0, 64'h7FF0000000000001, 64'hFFFFFFFF7FC00000, 5'h10};
    vecs[17] = '{1'b1, 3'd4, 64'h3FF0000010000000, 64'hFFFFFFFF3F800001, 5'h01};
    vecs[18] = '{1'b1, 3'd0, 64'h3FF0000010000000, 64'hFFFFFFFF3F800000, 5'h01};
    vecs[19] = '{1'b0, 3'd0, 64'hFFFFFFFFBFC00000, 64'hBFF8000000000000, 5'h00};
    vecs[20] = '{1'b1, 3'd0, 64'h380FFFFFF0000000, 64'hFFFFFFFF00800000, 5'h01};
    vecs[21] = '{1'b1, 3'd0, 64'h47EFFFFFF0000000, 64'hFFFFFFFF7F800000, 5'h05};
    vecs[22] = '{1'b1, 3'd1, 64'h47EFFFFFF0000000, 64'hFFFFFFFF7F7FFFFF, 5'h01};
    vecs[23] = '{1'b1, 3'd0, 64'h3FF0000000000000, 64'hFFFFFFFF3F800000, 5'h00};
    vecs[24] = '{1'b1, 3'd5, 64'h3FF0000010000000, 64'hFFFFFFFF3F800000, 5'h01};
    vecs[25] = '{1'b0, 3'd0, 64'hFFFFFFFFFF800000, 64'hFFF0000000000000, 5'h00};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", out_data, 64'd0);
    check("reset out_flags", 64'(out_flags), 64'd0);
    check("reset out_tag", 64'(out_tag), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: the accepting edge is edge 1; out_valid follows the third edge.
    drive(0, 5'd7);
    @(negedge clk);
    check("lat in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    @(negedge clk);
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
      @(negedge clk);
    end
    check("latency edges", 64'(edges), 64'd3);
    check("lat data", out_data, 64'h3FF0000000000000);
    check("lat tag", 64'(out_tag), 64'd7);
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) apply_one(i);

    // Back-to-back stream of 6 ops with a 4-cycle output stall.
    sent = 0; got = 0; cyc = 0; stall_left = 0;
    stall_started = 1'b0; holding = 1'b0;
    h_data = '0; h_flags = '0; h_tag = '0;
    drive(0, 5'd0);
    while (got < 6 && cyc < 100) begin
      @(negedge clk);
      if (holding) begin
        check("stall data stable", out_data, h_data);
        check("stall flags stable", 64'(out_flags), 64'(h_flags));
        check("stall tag stable", 64'(out_tag), 64'(h_tag));
      end
      holding = out_valid && !out_ready;
      if (holding) begin
        check("stall in_ready", 64'(in_ready), 64'd0);
        h_data  = out_data;
        h_flags = out_flags;
        h_tag   = out_tag;
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream%0d tag", got), 64'(out_tag), 64'(got));
        check($sformatf("stream%0d data", got), out_data, vecs[got].res);
        check($sformatf("stream%0d flags", got), 64'(out_flags), 64'(vecs[got].flags));
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 6) drive(sent, 5'(sent));
        else in_valid = 1'b0;
      end
      if (!stall_started && out_valid) begin
        stall_started = 1'b1;
        out_ready     = 1'b0;
        stall_left    = 4;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end
    end
    check("stream count", 64'(got), 64'd6);
    check("stream stalled", 64'(stall_started), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset with one result presented and two more ops in flight.
    drive(1, 5'd1);
    @(posedge clk); #1;
    drive(2, 5'd2);
    @(posedge clk); #1;
    drive(3, 5'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset out_data", out_data, 64'd0);
    check("async reset out_tag", 64'(out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("stale results after reset", 64'(stale), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcvt_sd_pipe.md
Name: fcvt_sd_pipe

Overview:
Pipelined, bidirectional single<->double FP converter for the FPU, replacing the combinational S->D converter.
- Directions: FCVT.D.S (widen) and FCVT.S.D (narrow).
- Inputs: RISC-V rounding mode; NaN-boxed single operands.
- Outputs: IEEE-754 result plus fflags, with valid/ready handshakes on both sides.
- Placement: between the FPU issue mux and the FP writeback arbiter; a tag travels with each op.

Parameters:
BUS_WIDTH, 64, FP register/bus width; must be 64 (single results NaN-boxed).
TAG_WIDTH, 5, width of the opaque tag (destination register index).
STAGES, 3, pipeline depth; fixed at 3 (unpack / convert-normalise / round-pack).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  converter can accept this cycle
in_op  in  1  0 = S->D, 1 = D->S
in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
in_data  in  BUS_WIDTH  operand (single NaN-boxed in low 32 bits)
in_tag  in  TAG_WIDTH  passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  BUS_WIDTH  result; single results NaN-boxed (upper 32 bits all ones)
out_flags  out  5  fflags {NV,DZ,OF,UF,NX}; DZ always 0
out_tag  out  TAG_WIDTH  tag of the result

Behaviour:
Reset:
- Asynchronous, active-low; all stage valid bits clear, out_valid=0.
- out_data, out_flags and out_tag reset to 0.
- Reset mid-operation discards every in-flight op. No result emerges after reset releases.

Handshake and pipeline:
- Transfer on in_valid&in_ready; result on out_valid&out_ready.
- stall = out_valid & ~out_ready; in_ready = ~stall. The whole pipe freezes on stall.
- Bubbles advance (no bubble collapsing).
- Latency: exactly 3 cycles from accept to out_valid with no stall. Throughput 1/cycle.
- Order is preserved. Data, flags and tag are held stable while stalled.

Stage 1, unpack/classify:
- Extract sign, exponent, mantissa for the selected format.
- Classes: zero, subnormal, normal, inf, qNaN, sNaN.
- S->D only: an input whose upper 32 bits are not all ones is treated as canonical qNaN, with no NV.

Stage 2, convert:
- S->D:
  - Rebias exponent by +896.
  - Subnormal single: normalise via leading-zero count, exponent = 897 - lzc - 1 relative to 1023 bias. Result is always exact.
- D->S:
  - Rebias by -896; keep 24-bit significand plus guard, round and sticky.
  - Biased exponent <= 0: right-shift into subnormal range, sticky = OR of shifted-out bits; shift saturates at 26.

Stage 3, round/pack:
- Rounding: RNE ties-to-even; RTZ truncate; RDN/RUP toward -/+inf by sign; RMM ties-away.
- Mantissa carry-out increments exponent; a subnormal rounding up to min-normal becomes normal.
- Overflow (exponent >= 255 after rounding):
  - RNE, RMM: +/-inf.
  - RTZ: +/-0x7F7FFFFF.
  - RDN: +max for positive, -inf for negative.
  - RUP: the mirror of RDN (-max for negative, +inf for positive).
  - Flags OF|NX in every case.
- UF: tiny after rounding AND inexact.
- NX: any discarded nonzero bits.
- Zero keeps sign; inf maps to inf of the same sign.
- NaNs:
  - Any NaN input produces the canonical NaN (0x7FF8000000000000, or boxed 0x7FC00000).
  - sNaN input sets NV.
- Reserved rm (101, 110, 111) behaves as RNE; decode rejects these upstream.

Decomposition:
fpu_pkg holds:
- rm encodings;
- fflags bit indices;
- single/double exponent widths, mantissa widths and biases;
- canonical NaN constants;
- NaN-box mask;
- class enum (zero/sub/norm/inf/qnan/snan).

Sub-module fp_round performs generic significand rounding: inputs sign, rm, significand, guard, round, sticky; outputs rounded significand, carry, inexact. It is reused later by FADD/FMUL.

Test Plan:
1. S->D, rm=RNE, in_data=0xFFFFFFFF3F800000 -> out_data=0x3FF0000000000000, flags=0x00, out_valid exactly 3 cycles after accept.
2. D->S, in_data=0x3FF0000000000001:
   - RNE -> 0xFFFFFFFF3F800000, flags=0x01 (NX).
   - RUP -> 0xFFFFFFFF3F800001, flags=0x01.
3. D->S, in_data=0x7E37E43C8800759C (1e300):
   - RNE -> 0xFFFFFFFF7F800000, flags=0x05.
   - RTZ -> 0xFFFFFFFF7F7FFFFF, flags=0x05.
4. NaNs:
   - S->D 0xFFFFFFFF7F800001 (sNaN) -> 0x7FF8000000000000, flags=0x10.
   - S->D unboxed 0x000000003F800000 -> 0x7FF8000000000000, flags=0x00.
5. Subnormals and underflow:
   - S->D 0xFFFFFFFF00000001 -> 0x36A0000000000000, flags=0x00.
   - D->S 0x3690000000000000 (2^-150), RNE -> 0xFFFFFFFF00000000, flags=0x03.
6. Back-to-back and reset:
   - Stream 6 ops with tags 0..5; hold out_ready=0 for 4 cycles once out_valid rises -> in_ready=0 during stall, all 6 results emerge in tag order 0..5, each output stable while stalled.
   - Assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately; no stale results after release.
